// File: rtl/cnn_acc_requant_22s_14s.sv
// Signed product accumulator with shift/round/saturate requantization to a 14-bit result.
// Optional build macro ACC_ROUND_NEAREST_EN selects round-half-up instead of truncation.
module cnn_acc_requant_22s_14s #(
    parameter int PROD_WIDTH = 22,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 14,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [PROD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_sat
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // a source holds valid and data stable until that edge.

    localparam logic [1:0] ST_ACC = 2'd0;
    localparam logic [1:0] ST_QNT = 2'd1;
    localparam logic [1:0] ST_OUT = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [ACC_WIDTH:0]   OUT_MAX =
        (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH:0]   OUT_MIN = ~OUT_MAX;
`ifdef ACC_ROUND_NEAREST_EN
    localparam logic signed [ACC_WIDTH:0]   RND = (ACC_WIDTH+1)'((64'sd1 <<< FRAC_SHIFT) >>> 1);
`else
    localparam logic signed [ACC_WIDTH:0]   RND = '0;
`endif

    logic [1:0]                  state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        acc_sat;

    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH:0]    acc_x;
    logic signed [ACC_WIDTH:0]    prod_x;
    logic signed [ACC_WIDTH:0]    sum;
    logic                         sum_ovf;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [ACC_WIDTH:0]    rnd_sum;
    logic signed [ACC_WIDTH:0]    shifted;
    logic                         clip_hi;
    logic                         clip_lo;
    logic [OUT_WIDTH-1:0]         q_data;

    assign prod    = s_data;
    assign s_ready = (state == ST_ACC);

    always_comb begin
        acc_x   = (ACC_WIDTH+1)'(acc);
        prod_x  = (ACC_WIDTH+1)'(prod);
        sum     = acc_x + prod_x;
        // One guard bit: the add overflowed iff the top two bits disagree.
        sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        if (!sum_ovf) begin
            acc_next = sum[ACC_WIDTH-1:0];
        end else if (sum[ACC_WIDTH]) begin
            acc_next = ACC_MIN;
        end else begin
            acc_next = ACC_MAX;
        end

        rnd_sum = acc_x + RND;
        shifted = rnd_sum >>> FRAC_SHIFT;
        clip_hi = (shifted > OUT_MAX);
        clip_lo = (shifted < OUT_MIN);
        if (clip_hi) begin
            q_data = OUT_MAX[OUT_WIDTH-1:0];
        end else if (clip_lo) begin
            q_data = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            q_data = shifted[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= ST_ACC;
            acc     <= '0;
            acc_sat <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (s_valid) begin
                        acc <= acc_next;
                        if (sum_ovf) acc_sat <= 1'b1;
                        if (s_last) state <= ST_QNT;
                    end
                end
                ST_QNT: begin
                    m_data  <= q_data;
                    m_sat   <= clip_hi | clip_lo | acc_sat;
                    m_valid <= 1'b1;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        acc     <= '0;
                        acc_sat <= 1'b0;
                        state   <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_acc_requant_22s_14s.sv
// Directed bench for cnn_acc_requant_22s_14s: packet-level model plus literal expectations.
module tb_cnn_acc_requant_22s_14s;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [21:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [13:0] m_data;
    logic        m_sat;

    int checks   = 0;
    int failures = 0;

    logic [14:0] exp_q[$];
    int          pkt[$];
    logic [14:0] held;
    bit          seen = 0;

    cnn_acc_requant_22s_14s dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sat   (m_sat)
    );

    // clock
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Packet-level reference: saturating sum, floor shift by 8, clamp to 14 bits.
    function automatic void model_push();
        longint acc = 0;
        longint t;
        bit     sat = 0;
        bit     clip = 0;
        foreach (pkt[i]) begin
            acc = acc + pkt[i];
            if (acc > 64'sd2147483647) begin
                acc = 64'sd2147483647; sat = 1;
            end else if (acc < -64'sd2147483648) begin
                acc = -64'sd2147483648; sat = 1;
            end
        end
`ifdef ACC_ROUND_NEAREST_EN
        acc = acc + 128;
`endif
        t = acc >>> 8;
        if (t > 8191) begin
            t = 8191; clip = 1;
        end else if (t < -8192) begin
            t = -8192; clip = 1;
        end
        exp_q.push_back({sat | clip, 14'(t)});
    endfunction

    // driver: called at a negedge, returns at the negedge after the beat is taken
    task automatic send_beat(input int d, input bit last);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = 22'(d);
        s_last  = last;
        while (!s_ready && guard < 200) begin
            @(negedge ap_clk);
            guard++;
        end
        if (guard >= 200) check("beat_timeout", 0, 1);
        @(negedge ap_clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_packet();
        model_push();
        foreach (pkt[i]) send_beat(pkt[i], i == pkt.size() - 1);
    endtask

    task automatic wait_valid(input string name);
        int guard = 0;
        while (!m_valid && guard < 50) begin
            @(negedge ap_clk);
            guard++;
        end
        if (!m_valid) check({name, "_valid_timeout"}, 0, 1);
    endtask

    task automatic expect_result(input string name, input int d, input bit sat);
        wait_valid(name);
        check({name, "_data"}, longint'($signed(m_data)), d);
        check({name, "_sat"}, m_sat, sat);
        m_ready = 1'b1;
        @(negedge ap_clk);
        m_ready = 1'b0;
    endtask

    // scoreboard: every new result checked against the model; held results must not move
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            seen = 0;
        end else if (m_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    logic [14:0] e;
                    e = exp_q.pop_front();
                    check("model_result", {m_sat, m_data}, e);
                end
                held = {m_sat, m_data};
                seen = 1;
            end else begin
                check("hold_stable", {m_sat, m_data}, held);
            end
        end else begin
            seen = 0;
        end
    end

    initial begin
        ap_rst_n = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b0;
        repeat (2) @(negedge ap_clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_sat", m_sat, 0);
        check("rst_s_ready", s_ready, 1);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // 1: three beats, latency check
        pkt = '{256, 512, -128};
        model_push();
        send_beat(256, 0);
        send_beat(512, 0);
        send_beat(-128, 1);
        check("lat_t1", m_valid, 0);
        @(negedge ap_clk);
        check("lat_t2", m_valid, 1);
`ifdef ACC_ROUND_NEAREST_EN
        expect_result("t1", 3, 0);
`else
        expect_result("t1", 2, 0);
`endif

        // 2: single negative beat
        pkt = '{-384};
        send_packet();
`ifdef ACC_ROUND_NEAREST_EN
        expect_result("t2", -1, 0);
`else
        expect_result("t2", -2, 0);
`endif

        // 3: output clamp high, exact low bound
        pkt = '{2097151, 2097151};
        send_packet();
        expect_result("t3_hi", 8191, 1);
        pkt = '{-2097152};
        send_packet();
        expect_result("t3_lo", -8192, 0);

        // 4: backpressure
        pkt = '{1024};
        send_packet();
        wait_valid("t4");
        s_valid = 1'b1;
        s_data  = 22'(999);
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            check("t4_s_ready_low", s_ready, 0);
            check("t4_m_valid_held", m_valid, 1);
            check("t4_m_data_held", longint'($signed(m_data)), 4);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        @(negedge ap_clk);
        m_ready = 1'b0;
        check("t4_s_ready_back", s_ready, 1);
        check("t4_m_valid_drop", m_valid, 0);
        pkt = '{256};
        send_packet();
        expect_result("t4_next", 1, 0);

        // 5: reset mid-packet, then reset with a result pending
        send_beat(100, 0);
        send_beat(200, 0);
        #2 ap_rst_n = 1'b0;
        #1;
        check("t5_rst_s_ready", s_ready, 1);
        check("t5_rst_m_valid", m_valid, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        pkt = '{512};
        send_packet();
        expect_result("t5_after", 2, 0);
        pkt = '{-2097152, -2097152};
        send_packet();
        wait_valid("t5_pend");
        #2 ap_rst_n = 1'b0;
        #1;
        check("t5_pend_m_valid", m_valid, 0);
        check("t5_pend_m_data", m_data, 0);
        check("t5_pend_m_sat", m_sat, 0);
        check("t5_pend_s_ready", s_ready, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // 6: long packet saturating the accumulator, then a clean packet
        pkt.delete();
        for (int i = 0; i < 1100; i++) pkt.push_back(2097151);
        send_packet();
        expect_result("t6_sat", 8191, 1);
        pkt = '{512};
        send_packet();
        expect_result("t6_next", 2, 0);

        repeat (3) @(negedge ap_clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
